// File: rtl/fsm_ctrl_pkg.sv
// Shared types and constants for the timer initiator controller.
package fsm_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, ARM, WAIT, ACK, FAULT} state_t;

  // A healthy timer drops READY on the 2nd ACK cycle, so the 3rd is a fault.
  localparam int ACK_LIMIT = 3;

  function automatic int count_width(input int repeats);
    return (repeats < 1) ? 1 : $clog2(repeats + 1);
  endfunction

endpackage

// File: rtl/wd_counter.sv
// Watchdog cycle counter with synchronous clear and a terminal-count flag at LIMIT-1.
module wd_counter #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 1024
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] value,
  output logic             terminal
);

  assign terminal = (value == WIDTH'(LIMIT - 1));

  // Holds at the terminal count rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (enable && !terminal) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fsm_timer_ctrl.sv
// Initiator FSM that runs the attached timer REPEATS times per GO, with a watchdog for stuck timers.
module fsm_timer_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int TIMER_N  = 256,
  parameter int REPEATS  = 4,
  parameter int WATCHDOG = 1024
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic                             go,
  input  logic                             abort,
  input  logic                             ready,
  output logic                             start,
  output logic                             reset,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [count_width(REPEATS)-1:0]  count
);

  localparam int CW  = count_width(REPEATS);
  localparam int WDW = $clog2(WATCHDOG);
  localparam bit CFG_OK = (WATCHDOG > TIMER_N) && (REPEATS >= 1) && (WATCHDOG >= ACK_LIMIT);

  state_t          state;
  state_t          state_next;
  logic            abort_pend;
  logic [CW-1:0]   count_inc;
  logic            last_run;
  logic [WDW-1:0]  wd_value;
  logic            wd_term;
  logic            wd_clear;
  logic            wd_enable;

  assign count_inc = count + CW'(1);
  assign last_run  = (count_inc == CW'(REPEATS));
  assign wd_clear  = (state_next != state);
  assign wd_enable = (state == WAIT) || (state == ACK);

  wd_counter #(
    .WIDTH (WDW),
    .LIMIT (WATCHDOG)
  ) u_wd (
    .clk      (clk),
    .n_reset  (n_reset),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .value    (wd_value),
    .terminal (wd_term)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = ready ? FAULT : ARM;
      ARM:     state_next = WAIT;
      WAIT: begin
        if (ready) state_next = ACK;
        else if (wd_term) state_next = FAULT;
      end
      ACK: begin
        if (!ready) state_next = (abort_pend || last_run) ? IDLE : ARM;
        else if (wd_value == WDW'(ACK_LIMIT - 1)) state_next = FAULT;
      end
      FAULT:   if (abort && !ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_next;
  end

  // An abort only takes effect at the end of a run: the timer cannot be stopped mid-count.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count      <= '0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == ACK) && !ready && !abort_pend && last_run;
      if ((state == IDLE) && go && !ready) begin
        count      <= '0;
        abort_pend <= 1'b0;
      end else begin
        if ((state == ACK) && !ready && (count != CW'(REPEATS))) count <= count_inc;
        if (abort && ((state == ARM) || (state == WAIT) || (state == ACK))) abort_pend <= 1'b1;
      end
    end
  end

  // Control outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      start <= 1'b0;
      reset <= 1'b0;
      busy  <= 1'b0;
      error <= 1'b0;
    end else begin
      start <= (state_next == ARM);
      reset <= (state_next == ACK) || (state_next == FAULT);
      busy  <= (state_next != IDLE);
      error <= (state_next == FAULT);
    end
  end

  cfg_check: assert property (@(posedge clk) disable iff (!n_reset) CFG_OK);
  count_range: assert property (@(posedge clk) disable iff (!n_reset) count <= CW'(REPEATS));

endmodule

// File: tb/tb_fsm_timer_ctrl.sv
// Self-checking bench: timer model plus a cycle-offset reference model of the controller.
module tb_fsm_timer_ctrl;

  localparam int N  = 4;
  localparam int R  = 2;
  localparam int WD = 16;
  localparam int P  = N + 2;
  localparam int CW = $clog2(R + 1);

  logic          clk = 1'b0;
  logic          n_reset;
  logic          go;
  logic          abort;
  logic          ready;
  logic          start;
  logic          reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] count;

  int mode = 0;
  int tcnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  bit seq_on = 0;
  int off = 0;
  int runs_total = 0;
  bit aborted = 0;
  int idle_count = 0;

  fsm_timer_ctrl #(
    .TIMER_N  (N),
    .REPEATS  (R),
    .WATCHDOG (WD)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .go      (go),
    .abort   (abort),
    .ready   (ready),
    .start   (start),
    .reset   (reset),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .count   (count)
  );

  always #5 clk = ~clk;

  // Timer: START begins a count, READY holds at N-1 until RESET returns it to zero.
  always @(posedge clk) begin
    if (!n_reset || reset) tcnt <= 0;
    else if (start) tcnt <= 1;
    else if (tcnt != 0 && tcnt < N - 1) tcnt <= tcnt + 1;
  end

  assign ready = (mode == 0) ? (tcnt == N - 1) : (mode == 2);

  task automatic checkOutput(input string tag, input logic e_start, input logic e_reset,
                             input logic e_busy, input logic e_done, input logic e_error,
                             input int e_count);
    n_checks++;
    assert (start === e_start) else begin n_fail++; $error("[TB] FAIL %s.start got %b want %b", tag, start, e_start); end
    n_checks++;
    assert (reset === e_reset) else begin n_fail++; $error("[TB] FAIL %s.reset got %b want %b", tag, reset, e_reset); end
    n_checks++;
    assert (busy === e_busy) else begin n_fail++; $error("[TB] FAIL %s.busy got %b want %b", tag, busy, e_busy); end
    n_checks++;
    assert (done === e_done) else begin n_fail++; $error("[TB] FAIL %s.done got %b want %b", tag, done, e_done); end
    n_checks++;
    assert (error === e_error) else begin n_fail++; $error("[TB] FAIL %s.error got %b want %b", tag, error, e_error); end
    n_checks++;
    assert (count === CW'(e_count)) else begin n_fail++; $error("[TB] FAIL %s.count got %0d want %0d", tag, count, e_count); end
  endtask

  task automatic applyStimulus(input logic g, input logic a, input logic r);
    go = g;
    abort = a;
    n_reset = r;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs follow from the offset since GO: run = (off-1)/P, phase = (off-1)%P.
  task automatic modelCycle(input string tag, input bit g, input bit want_abort, input bit r);
    int endc, ph, run;
    bit idle_now, a;
    logic es, er, eb, ed;
    int ec;
    es = 0; er = 0; eb = 0; ed = 0; ec = idle_count;
    ph = -1; run = 0; idle_now = 1;
    endc = runs_total * P;
    if (seq_on) begin
      if (off <= endc) begin
        idle_now = 0;
        ph = (off - 1) % P;
        run = (off - 1) / P;
        es = (ph == 0);
        er = (ph >= N);
        eb = 1;
        ec = run;
      end else begin
        ec = runs_total;
        ed = (off == endc + 1) && !aborted;
      end
    end
    checkOutput(tag, es, er, eb, ed, 1'b0, ec);
    a = want_abort && (ph != N + 1);
    if (!r) begin
      seq_on = 0;
      idle_count = 0;
    end else if (idle_now && g) begin
      seq_on = 1;
      off = 1;
      runs_total = R;
      aborted = 0;
    end else if (seq_on) begin
      if (a && !idle_now && !aborted) begin
        aborted = 1;
        runs_total = run + 1;
      end
      off++;
      if (off > runs_total * P + 1) begin
        seq_on = 0;
        idle_count = runs_total;
      end
    end
    applyStimulus(g, a, r);
  endtask

  initial begin
    bit rg, ra, rr;
    go = 0; abort = 0; n_reset = 0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);

    $display("[TB] nominal sequence");
    modelCycle("nom", 1, 0, 1);
    for (int i = 0; i < 15; i++) modelCycle("nom", 0, 0, 1);

    $display("[TB] abort during first run");
    modelCycle("abt", 1, 0, 1);
    modelCycle("abt", 0, 0, 1);
    modelCycle("abt", 0, 0, 1);
    modelCycle("abt", 0, 1, 1);
    for (int i = 0; i < 8; i++) modelCycle("abt", 0, 0, 1);

    $display("[TB] reset mid-run then clean sequence");
    modelCycle("rst", 1, 0, 1);
    for (int i = 0; i < 3; i++) modelCycle("rst", 0, 0, 1);
    modelCycle("rst", 0, 0, 0);
    for (int i = 0; i < 3; i++) modelCycle("rst", 0, 0, 1);
    modelCycle("rst2", 1, 0, 1);
    for (int i = 0; i < 15; i++) modelCycle("rst2", 0, 0, 1);

    $display("[TB] go held high");
    for (int i = 0; i < 3 * R * P + 4; i++) modelCycle("hold", 1, 0, 1);
    for (int i = 0; i < R * P + 3; i++) modelCycle("hold", 0, 0, 1);

    $display("[TB] random stimulus");
    for (int i = 0; i < 600; i++) begin
      rg = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 11) == 0);
      rr = ($urandom_range(0, 149) != 0);
      modelCycle("rand", rg, ra, rr);
    end
    for (int i = 0; i < R * P + 3; i++) modelCycle("drain", 0, 0, 1);

    $display("[TB] watchdog with timer removed");
    mode = 1;
    checkOutput("wd_idle", 0, 0, 0, 0, 0, idle_count);
    applyStimulus(1, 0, 1);
    checkOutput("wd_arm", 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1);
    for (int k = 0; k < WD; k++) begin
      checkOutput("wd_wait", 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1);
    end
    checkOutput("wd_fault", 0, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 1);
    checkOutput("wd_hold", 0, 1, 1, 0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("wd_clear", 0, 0, 0, 0, 0, 0);

    $display("[TB] go while timer not at rest");
    mode = 2;
    applyStimulus(1, 0, 1);
    checkOutput("rdy_fault", 0, 1, 1, 0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("rdy_stuck", 0, 1, 1, 0, 1, 0);
    mode = 0;
    applyStimulus(0, 1, 1);
    checkOutput("rdy_clear", 0, 0, 0, 0, 0, 0);

    $display("[TB] ready stuck during ack");
    applyStimulus(1, 0, 1);
    checkOutput("ack_arm", 1, 0, 1, 0, 0, 0);
    for (int k = 0; k < N - 1; k++) begin
      applyStimulus(0, 0, 1);
      checkOutput("ack_wait", 0, 0, 1, 0, 0, 0);
    end
    applyStimulus(0, 0, 1);
    mode = 2;
    for (int k = 0; k < 3; k++) begin
      checkOutput("ack_cycle", 0, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 1);
    end
    checkOutput("ack_fault", 0, 1, 1, 0, 1, 0);
    mode = 0;
    applyStimulus(0, 1, 1);
    checkOutput("ack_clear", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
